apb_bus_bridge: RTL and testbench

Bridges the CPU datapath's data-memory port (busAddr/busWData/busWe/busFunc3/busRData) to an APB3 peripheral bus with four fixed slaves. It sits directly downstream of the datapath's memory-access stage. It latches one request and decodes the slave. It generates byte strobes and replicates write data. It runs the APB SETUP/ACCESS sequence and returns LSB-aligned read data with a one-cycle completion pulse. Sign/zero extension stays in the datapath's load path, not here.

---
 rtl/apb_bus_pkg.sv | 46 ++++
 rtl/apb_lane_align.sv | 36 +++
 rtl/apb_bus_bridge.sv | 151 +++++++++++++++
 tb/tb_apb_bus_bridge.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_bus_pkg.sv
// Shared types and constants for the CPU data-port to APB3 bridge.
package apb_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    localparam int SLV_COUNT = 4;

    localparam logic [SLV_COUNT-1:0][19:0] SLV_BASE = {
        20'h10003,
        20'h10002,
        20'h10001,
        20'h10000
    };

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic func3_ok(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic [3:0] strb_gen(
        input logic [2:0] f3,
        input logic [1:0] lo
    );
        logic [3:0] s;
        s = 4'b0000;
        unique case (1'b1)
            (f3[1:0] == 2'b00): s = 4'b0001 << lo;
            (f3[1:0] == 2'b01): s = 4'b0011 << {lo[1], 1'b0};
            (f3[1:0] == 2'b10): s = 4'b1111;
            default:            s = 4'b0000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/apb_lane_align.sv
// Byte-lane steering: strobes, write replication, read alignment.
module apb_lane_align
    import apb_bus_pkg::*;
(
    input  logic [2:0]  i_func3,
    input  logic [1:0]  i_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_prdata,
    output logic [3:0]  o_strb,
    output logic [31:0] o_pwdata,
    output logic [31:0] o_rdata,
    output logic        o_misaligned
);

    assign o_strb  = strb_gen(i_func3, i_lo);
    assign o_rdata = i_prdata >> {i_lo, 3'b000};

    always_comb begin
        o_pwdata     = i_wdata;
        o_misaligned = 1'b0;
        unique case (1'b1)
            (i_func3[1:0] == 2'b00): begin
                o_pwdata = {4{i_wdata[7:0]}};
            end
            (i_func3[1:0] == 2'b01): begin
                o_pwdata     = {2{i_wdata[15:0]}};
                o_misaligned = i_lo[0];
            end
            (i_func3[1:0] == 2'b10): begin
                o_misaligned = (i_lo != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/apb_bus_bridge.sv
// Single-outstanding CPU data-port to APB3 bridge, four fixed slaves.
module apb_bus_bridge
    import apb_bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    busReq,
    input  logic [31:0]             busAddr,
    input  logic [31:0]             busWData,
    input  logic                    busWe,
    input  logic [2:0]              busFunc3,
    output logic [31:0]             busRData,
    output logic                    busReady,
    output logic                    busErr,
    output logic [31:0]             PADDR,
    output logic [SLV_COUNT-1:0]    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [31:0]             PWDATA,
    output logic [3:0]              PSTRB,
    input  logic [SLV_COUNT*32-1:0] PRDATA,
    input  logic [SLV_COUNT-1:0]    PREADY
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [2:0]  r_func3;
    logic [1:0]  r_lo;
    logic [1:0]  r_idx;
    logic [7:0]  r_cnt;

    logic        w_idle;
    logic [2:0]  w_f3;
    logic [1:0]  w_lo;
    logic        w_hit;
    logic [1:0]  w_idx;
    logic [31:0] w_prdata;
    logic [3:0]  w_strb;
    logic [31:0] w_pwdata;
    logic [31:0] w_rdata;
    logic        w_mis;
    logic        w_legal;
    logic        w_ready;
    logic        w_tmo;

    // In IDLE the aligner looks at the live request; afterwards at the latch.
    assign w_idle   = (r_state == ST_IDLE);
    assign w_f3     = w_idle ? busFunc3 : r_func3;
    assign w_lo     = w_idle ? busAddr[1:0] : r_lo;
    assign w_prdata = PRDATA[{r_idx, 5'b00000} +: 32];

    always_comb begin
        w_hit = 1'b0;
        w_idx = 2'b00;
        for (int i = 0; i < SLV_COUNT; i++) begin
            if (busAddr[31:12] == SLV_BASE[i]) begin
                w_hit = 1'b1;
                w_idx = i[1:0];
            end
        end
    end

    apb_lane_align u_align (
        .i_func3      (w_f3),
        .i_lo         (w_lo),
        .i_wdata      (busWData),
        .i_prdata     (w_prdata),
        .o_strb       (w_strb),
        .o_pwdata     (w_pwdata),
        .o_rdata      (w_rdata),
        .o_misaligned (w_mis)
    );

    assign w_legal = w_hit && func3_ok(busFunc3) && !w_mis;
    assign w_ready = PREADY[r_idx];
    assign w_tmo   = (TIMEOUT != 0) && (r_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_func3  <= 3'b000;
            r_lo     <= 2'b00;
            r_idx    <= 2'b00;
            r_cnt    <= 8'd0;
            busRData <= 32'd0;
            busReady <= 1'b0;
            busErr   <= 1'b0;
            PADDR    <= 32'd0;
            PSEL     <= '0;
            PENABLE  <= 1'b0;
            PWRITE   <= 1'b0;
            PWDATA   <= 32'd0;
            PSTRB    <= 4'b0000;
        end else begin
            busReady <= 1'b0;
            busErr   <= 1'b0;
            busRData <= 32'd0;
            unique case (r_state)
                ST_IDLE: begin
                    if (busReq && w_legal) begin
                        r_state <= ST_SETUP;
                        r_func3 <= busFunc3;
                        r_lo    <= busAddr[1:0];
                        r_idx   <= w_idx;
                        PADDR   <= {busAddr[31:2], 2'b00};
                        PWRITE  <= busWe;
                        PWDATA  <= w_pwdata;
                        PSTRB   <= busWe ? w_strb : 4'b0000;
                        PSEL    <= 4'b0001 << w_idx;
                    end else if (busReq) begin
                        r_state  <= ST_RESP;
                        busReady <= 1'b1;
                        busErr   <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_ACCESS;
                    PENABLE <= 1'b1;
                    r_cnt   <= 8'd0;
                end
                ST_ACCESS: begin
                    if (w_ready) begin
                        r_state  <= ST_IDLE;
                        busReady <= 1'b1;
                        busRData <= PWRITE ? 32'd0 : w_rdata;
                        PSEL     <= '0;
                        PENABLE  <= 1'b0;
                    end else if (w_tmo) begin
                        r_state  <= ST_IDLE;
                        busReady <= 1'b1;
                        busErr   <= 1'b1;
                        PSEL     <= '0;
                        PENABLE  <= 1'b0;
                    end else if (r_cnt != 8'hFF) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_bus_bridge.sv
// Directed scoreboard bench for apb_bus_bridge.
`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            failures++; \
            $error("FAIL %s obs=%0h exp=%0h", tag, (obs), (exp)); \
        end \
    end

module tb_apb_bus_bridge;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         busReq;
    logic [31:0]  busAddr;
    logic [31:0]  busWData;
    logic         busWe;
    logic [2:0]   busFunc3;
    logic [31:0]  busRData;
    logic         busReady;
    logic         busErr;
    logic [31:0]  PADDR;
    logic [3:0]   PSEL;
    logic         PENABLE;
    logic         PWRITE;
    logic [31:0]  PWDATA;
    logic [3:0]   PSTRB;
    logic [127:0] PRDATA;
    logic [3:0]   PREADY;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    resp_t sbq[$];

    always #5 clk = ~clk;

    apb_bus_bridge #(.TIMEOUT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .busReq   (busReq),
        .busAddr  (busAddr),
        .busWData (busWData),
        .busWe    (busWe),
        .busFunc3 (busFunc3),
        .busRData (busRData),
        .busReady (busReady),
        .busErr   (busErr),
        .PADDR    (PADDR),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PSTRB    (PSTRB),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d,
                         input logic we, input logic [2:0] f3,
                         input logic err, input logic [31:0] rd);
        busAddr  = a;
        busWData = d;
        busWe    = we;
        busFunc3 = f3;
        busReq   = 1'b1;
        sbq.push_back('{err: err, rdata: rd});
    endtask

    task automatic check_resp();
        resp_t e;
        `CHK("ready", busReady, 1'b1)
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb_empty obs=%0d exp=1", sbq.size());
        end else begin
            e = sbq.pop_front();
            `CHK("err", busErr, e.err)
            `CHK("rdata", busRData, e.rdata)
        end
    endtask

    task automatic wait_resp(input int budget);
        int n = 0;
        while (busReady !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check_resp();
    endtask

    initial begin
        int t0;
        rst      = 1'b1;
        busReq   = 1'b0;
        busAddr  = 32'd0;
        busWData = 32'd0;
        busWe    = 1'b0;
        busFunc3 = 3'b010;
        PRDATA   = '0;
        PREADY   = 4'b1111;
        tick();
        tick();
        `CHK("rst_ctl", {PSEL, PENABLE, PWRITE, PSTRB, busReady, busErr}, 12'h000)
        `CHK("rst_paddr", PADDR, 32'd0)
        `CHK("rst_pwdata", PWDATA, 32'd0)
        `CHK("rst_rdata", busRData, 32'd0)
        rst = 1'b0;
        tick();

        // LW, zero wait
        PRDATA[31:0] = 32'hDEADBEEF;
        drive(32'h1000_0008, 32'd0, 1'b0, 3'b010, 1'b0, 32'hDEADBEEF);
        tick();
        busReq = 1'b0;
        `CHK("lw_sel1", PSEL, 4'b0001)
        `CHK("lw_en1", PENABLE, 1'b0)
        `CHK("lw_paddr", PADDR, 32'h1000_0008)
        `CHK("lw_strb", PSTRB, 4'b0000)
        tick();
        `CHK("lw_sel2", PSEL, 4'b0001)
        `CHK("lw_en2", PENABLE, 1'b1)
        tick();
        check_resp();
        `CHK("lw_sel3", PSEL, 4'b0000)
        tick();

        // SB to top byte lane
        drive(32'h1000_1003, 32'h0000_00A5, 1'b1, 3'b000, 1'b0, 32'd0);
        tick();
        busReq = 1'b0;
        `CHK("sb_strb", PSTRB, 4'b1000)
        `CHK("sb_pwdata", PWDATA, 32'hA5A5_A5A5)
        `CHK("sb_paddr", PADDR, 32'h1000_1000)
        `CHK("sb_pwrite", PWRITE, 1'b1)
        `CHK("sb_sel", PSEL, 4'b0010)
        tick();
        `CHK("sb_en", PENABLE, 1'b1)
        tick();
        check_resp();
        tick();

        // LHU with three wait states, other slaves ready
        PRDATA[95:64] = 32'h1234_5678;
        PREADY = 4'b1011;
        drive(32'h1000_2002, 32'hFFFF_FFFF, 1'b0, 3'b101, 1'b0, 32'h0000_1234);
        tick();
        busReq = 1'b0;
        `CHK("lh_sel", PSEL, 4'b0100)
        for (int k = 2; k <= 4; k++) begin
            tick();
            `CHK("lh_wait_rdy", busReady, 1'b0)
            `CHK("lh_wait_en", PENABLE, 1'b1)
            `CHK("lh_paddr_stable", PADDR, 32'h1000_2000)
            `CHK("lh_pwdata_stable", PWDATA, 32'hFFFF_FFFF)
        end
        tick();
        `CHK("lh_c5_rdy", busReady, 1'b0)
        PREADY = 4'b1111;
        tick();
        check_resp();
        tick();

        // Misaligned word and unmapped address
        drive(32'h1000_0002, 32'h1111_1111, 1'b1, 3'b010, 1'b1, 32'd0);
        tick();
        busReq = 1'b0;
        check_resp();
        `CHK("mis_sel", PSEL, 4'b0000)
        tick();
        `CHK("mis_c2_rdy", busReady, 1'b0)
        drive(32'h2000_0000, 32'd0, 1'b0, 3'b010, 1'b1, 32'd0);
        tick();
        busReq = 1'b0;
        check_resp();
        `CHK("unm_sel", PSEL, 4'b0000)
        tick();
        drive(32'h1000_0000, 32'd0, 1'b0, 3'b011, 1'b1, 32'd0);
        tick();
        busReq = 1'b0;
        check_resp();
        tick();

        // Timeout on slave 3
        PRDATA[127:96] = 32'hCAFE_F00D;
        PREADY = 4'b0111;
        drive(32'h1000_3000, 32'd0, 1'b0, 3'b010, 1'b1, 32'd0);
        tick();
        busReq = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            tick();
            `CHK("to_wait_sel", PSEL, 4'b1000)
            `CHK("to_wait_rdy", busReady, 1'b0)
        end
        tick();
        check_resp();
        `CHK("to_sel_drop", PSEL, 4'b0000)
        tick();

        // Reset during ACCESS
        drive(32'h1000_3004, 32'd0, 1'b0, 3'b010, 1'b0, 32'd0);
        void'(sbq.pop_back());
        tick();
        busReq = 1'b0;
        tick();
        `CHK("rstm_en", PENABLE, 1'b1)
        rst = 1'b1;
        tick();
        rst = 1'b0;
        `CHK("rstm_ctl", {PSEL, PENABLE, PWRITE, PSTRB, busReady, busErr}, 12'h000)
        `CHK("rstm_paddr", PADDR, 32'd0)
        `CHK("rstm_rdata", busRData, 32'd0)
        PREADY = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick();
            `CHK("rstm_no_rdy", busReady, 1'b0)
        end

        // Back-to-back, next request issued in each busReady cycle
        t0 = cyc;
        drive(32'h1000_0001, 32'd0, 1'b0, 3'b100, 1'b0, 32'h00DE_ADBE);
        tick();
        busReq = 1'b0;
        wait_resp(10);
        `CHK("b2b_t1", cyc - t0, 3)
        drive(32'h1000_2000, 32'd0, 1'b0, 3'b010, 1'b0, 32'h1234_5678);
        tick();
        busReq = 1'b0;
        wait_resp(10);
        `CHK("b2b_t2", cyc - t0, 6)
        drive(32'h1000_1002, 32'h0000_BEEF, 1'b1, 3'b001, 1'b0, 32'd0);
        tick();
        busReq = 1'b0;
        `CHK("b2b_hstrb", PSTRB, 4'b1100)
        `CHK("b2b_hdata", PWDATA, 32'hBEEF_BEEF)
        wait_resp(10);
        `CHK("b2b_t3", cyc - t0, 9)
        `CHK("sb_drained", sbq.size(), 0)

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
